rr_sel_arb_4: RTL and testbench

- Round-robin arbiter for four valid/ready sources of WIDTH-bit data, merged into one output stream.
- Sits directly upstream of the team's 4:1 datapath muxes: its registered out_sel is the 2-bit select code and out_data is the selected word.
- A one-entry output register decouples downstream backpressure from arbitration.

---
 rtl/rr_sel_arb_pkg.sv | 13 +
 rtl/rr_pick_4.sv | 43 ++++
 rtl/rr_sel_arb_4.sv | 127 ++++++++++++
 tb/tb_rr_sel_arb_4.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_sel_arb_pkg.sv
// rtl/rr_sel_arb_pkg.sv - shared widths and types for the 4-source round-robin select arbiter
package rr_sel_arb_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational rotate / fixed-priority / rotate-back round-robin picker
module rr_pick_4 import rr_sel_arb_pkg::*; (
    input  logic [3:0] req,
    input  sel_t       ptr,
    output logic [3:0] win,
    output sel_t       idx,
    output logic       any
);

    logic [7:0] req2;
    logic [7:0] win2;
    logic [3:0] rot;
    logic [3:0] rot_win;
    sel_t       rot_idx;
    logic [2:0] back_sh;

    // Rotate requests so ptr sits at bit 0, pick the lowest set bit, then rotate the winner back
    always_comb begin
        req2    = {req, req};
        rot     = req2[{1'b0, ptr} +: 4];
        rot_win = 4'b0000;
        rot_idx = '0;
        if (rot[0]) begin
            rot_win = 4'b0001;
            rot_idx = 2'd0;
        end else if (rot[1]) begin
            rot_win = 4'b0010;
            rot_idx = 2'd1;
        end else if (rot[2]) begin
            rot_win = 4'b0100;
            rot_idx = 2'd2;
        end else if (rot[3]) begin
            rot_win = 4'b1000;
            rot_idx = 2'd3;
        end
        win2    = {rot_win, rot_win};
        back_sh = 3'd4 - {1'b0, ptr};
        win     = win2[back_sh +: 4];
        idx     = ptr + rot_idx;
        any     = |req;
    end

endmodule

// File: rtl/rr_sel_arb_4.sv
// rtl/rr_sel_arb_4.sv - 4:1 round-robin valid/ready arbiter with registered data/select (stats: RR_SEL_ARB_STATS_EN)
module rr_sel_arb_4 import rr_sel_arb_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output sel_t             out_sel
`ifdef RR_SEL_ARB_STATS_EN
    ,
    output cnt_t             grant_cnt0,
    output cnt_t             grant_cnt1,
    output cnt_t             grant_cnt2,
    output cnt_t             grant_cnt3
`endif
);

    sel_t             ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    sel_t             sel_q, sel_d;

    logic [3:0]       pick_win;
    sel_t             pick_idx;
    logic             pick_any;
    logic             can_load;
    logic             src_xfer;
    logic [WIDTH-1:0] pick_data;

    rr_pick_4 u_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant only when the output register is free or draining this cycle; rst blanks all readies
    always_comb begin
        can_load = !valid_q || out_ready;
        in_ready = (can_load && pick_any && !rst) ? pick_win : 4'b0000;
        src_xfer = |(in_ready & in_valid);
        case (pick_idx)
            2'd0:    pick_data = in_data0;
            2'd1:    pick_data = in_data1;
            2'd2:    pick_data = in_data2;
            default: pick_data = in_data3;
        endcase
    end

    // Next state: load on a source transfer (even while draining), otherwise drop valid on drain
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (src_xfer) begin
            valid_d = 1'b1;
            data_d  = pick_data;
            sel_d   = pick_idx;
            ptr_d   = pick_idx + sel_t'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pointer and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

`ifdef RR_SEL_ARB_STATS_EN
    cnt_t cnt_q [N_SRC];
    cnt_t cnt_d [N_SRC];

    // Saturating per-source transfer counters
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (in_ready[i] && in_valid[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end
        end
    end

    // Counter registers, cleared with the rest of the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign grant_cnt0 = cnt_q[0];
    assign grant_cnt1 = cnt_q[1];
    assign grant_cnt2 = cnt_q[2];
    assign grant_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_rr_sel_arb_4.sv
// tb/tb_rr_sel_arb_4.sv - directed self-checking bench for rr_sel_arb_4
module tb_rr_sel_arb_4;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;
`ifdef RR_SEL_ARB_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;
`endif

    int checks;
    int failures;

    rr_sel_arb_4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef RR_SEL_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .grant_cnt2 (grant_cnt2),
        .grant_cnt3 (grant_cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, release 1 unit after an edge
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data0  = 4'hA;
        in_data1  = 4'hB;
        in_data2  = 4'hC;
        in_data3  = 4'hD;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #2;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
        end
        do_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_all_valid_rotation();
        logic [3:0] exp_rdy;
        logic [1:0] exp_sel;
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rotate_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy);
            end
            if (k > 0) begin
                exp_sel = 2'((k - 1) % 4);
                checks++;
                if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== (4'hA + 4'(exp_sel))) begin
                    failures++;
                    $display("FAIL rotate_out k=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                             k, out_valid, out_sel, out_data, exp_sel, 4'hA + 4'(exp_sel));
                end
            end
            tick();
        end
    endtask

    task automatic test_single_source();
        do_reset();
        in_data2  = 4'h5;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0100) begin
                failures++;
                $display("FAIL single_ready k=%0d got=%b exp=0100", k, in_ready);
            end
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 4'h5 || out_sel !== 2'd2) begin
                    failures++;
                    $display("FAIL single_out k=%0d got v=%b d=%h s=%0d exp v=1 d=5 s=2", k, out_valid, out_data, out_sel);
                end
            end
            tick();
        end
        // ptr should be 3: with everyone requesting, source 3 is next
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            failures++;
            $display("FAIL single_ptr got=%b exp=1000", in_ready);
        end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd0) begin
                failures++;
                $display("FAIL stall k=%0d got r=%b v=%b d=%h s=%0d exp r=0000 v=1 d=a s=0",
                         k, in_ready, out_valid, out_data, out_sel);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            failures++;
            $display("FAIL stall_release got=%b exp=0010", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'hB) begin
            failures++;
            $display("FAIL stall_after got v=%b s=%0d d=%h exp v=1 s=1 d=b", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_first got=%b exp=1000", in_ready);
        end
        tick();
        in_valid = 4'b1001;
        #1;
        checks++;
        if (in_ready !== 4'b0001 || out_sel !== 2'd3 || out_data !== 4'hD) begin
            failures++;
            $display("FAIL wrap_second got r=%b s=%0d d=%h exp r=0001 s=3 d=d", in_ready, out_sel, out_data);
        end
        tick();
        in_valid = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'hA) begin
            failures++;
            $display("FAIL wrap_out got v=%b s=%0d d=%h exp v=1 s=0 d=a", out_valid, out_sel, out_data);
        end
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL drain_idle got v=%b r=%b exp v=0 r=0000", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        tick();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2) begin
            failures++;
            $display("FAIL areset_setup got v=%b s=%0d exp v=1 s=2", out_valid, out_sel);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0 || in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL areset_now got v=%b s=%0d d=%h r=%b exp v=0 s=0 d=0 r=0000",
                     out_valid, out_sel, out_data, in_ready);
        end
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL areset_first got=%b exp=0001", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'hA) begin
            failures++;
            $display("FAIL areset_out got v=%b s=%0d d=%h exp v=1 s=0 d=a", out_valid, out_sel, out_data);
        end
    endtask

`ifdef RR_SEL_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (grant_cnt1 !== 8'd10) begin
            failures++;
            $display("FAIL stats_ten got=%0d exp=10", grant_cnt1);
        end
        for (int k = 0; k < 290; k++) tick();
        checks++;
        if (grant_cnt1 !== 8'd255 || grant_cnt0 !== 8'd0 || grant_cnt2 !== 8'd0 || grant_cnt3 !== 8'd0) begin
            failures++;
            $display("FAIL stats_sat got c0=%0d c1=%0d c2=%0d c3=%0d exp 0 255 0 0",
                     grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3);
        end
        in_valid = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data0  = 4'hA;
        in_data1  = 4'hB;
        in_data2  = 4'hC;
        in_data3  = 4'hD;
        test_reset();
        test_all_valid_rotation();
        test_single_source();
        test_stall();
        test_wrap();
        test_async_reset();
`ifdef RR_SEL_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
